evolve_rate_ctrl: RTL

EVOLVE_RATE_CTRL -- requirements
Module: evolve_rate_ctrl

---
 rtl/gol_pkg.sv | 18 +
 rtl/rise_edge.sv | 21 ++
 rtl/evolve_rate_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - mode encodings and default parameters shared by the evolve rate controller
package gol_pkg;

    typedef enum logic [1:0] {
        MODE_PAUSE  = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int DEF_ACC_W      = 25;
    localparam int DEF_STEP_W     = 21;
    localparam int DEF_STEP_INIT  = 1024;
    localparam int DEF_STEP_DELTA = 1024;
    localparam int DEF_STEP_MIN   = 1;
    localparam int DEF_GEN_W      = 16;

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - one-cycle rising-edge detector; prev resets high so a level held through reset is ignored
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= in_i;
        end
    end

    assign edge_o = in_i & ~prev_q;

endmodule

// File: rtl/evolve_rate_ctrl.sv
// rtl/evolve_rate_ctrl.sv - phase-accumulator tick generator with saturating step control
// Optional gen counter built only when EVOLVE_GEN_COUNTER_EN is defined.
module evolve_rate_ctrl
    import gol_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int STEP_W     = DEF_STEP_W,
    parameter int STEP_INIT  = DEF_STEP_INIT,
    parameter int STEP_DELTA = DEF_STEP_DELTA,
    parameter int STEP_MIN   = DEF_STEP_MIN,
    parameter int STEP_MAX   = (1 << STEP_W) - 1,
    parameter int GEN_W      = DEF_GEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              inc_v,
    input  logic              dec_v,
    input  logic              step_req,
    output logic              envolve_v,
    output logic [STEP_W-1:0] step,
    output logic [ACC_W-1:0]  count,
    output logic              at_min,
    output logic              at_max,
    output logic [GEN_W-1:0]  gen
);

    localparam logic [STEP_W-1:0] STEP_INIT_V = STEP_W'(STEP_INIT);
    localparam logic [STEP_W-1:0] STEP_MIN_V  = STEP_W'(STEP_MIN);
    localparam logic [STEP_W-1:0] STEP_MAX_V  = STEP_W'(STEP_MAX);
    localparam logic [STEP_W:0]   MAX_X       = (STEP_W+1)'(STEP_MAX);
    localparam logic [STEP_W:0]   DELTA_X     = (STEP_W+1)'(STEP_DELTA);

    logic inc_edge, dec_edge, req_edge;

    rise_edge u_inc_edge (.clk(clk), .rst(rst), .in_i(inc_v),    .edge_o(inc_edge));
    rise_edge u_dec_edge (.clk(clk), .rst(rst), .in_i(dec_v),    .edge_o(dec_edge));
    rise_edge u_req_edge (.clk(clk), .rst(rst), .in_i(step_req), .edge_o(req_edge));

    logic [STEP_W-1:0] step_q, step_d;
    logic [ACC_W-1:0]  count_q, count_d;
    logic              tick_q, tick_d;
    logic [STEP_W:0]   inc_sum;
    logic signed [STEP_W+1:0] dec_diff;
    logic [ACC_W:0]    acc_sum;
    mode_e             mode_s;

    assign mode_s = mode_e'(mode);

    // Extra headroom bits keep saturation decisions free of wrap/underflow.
    always_comb begin
        inc_sum  = {1'b0, step_q} + DELTA_X;
        dec_diff = $signed({2'b00, step_q}) - $signed((STEP_W+2)'(STEP_DELTA));
        step_d   = step_q;
        if (inc_edge && !dec_edge) begin
            step_d = (inc_sum > MAX_X) ? STEP_MAX_V : inc_sum[STEP_W-1:0];
        end else if (dec_edge && !inc_edge) begin
            step_d = (dec_diff < $signed((STEP_W+2)'(STEP_MIN))) ? STEP_MIN_V
                                                                 : dec_diff[STEP_W-1:0];
        end
    end

    always_comb begin
        acc_sum = {1'b0, count_q} + (ACC_W+1)'(step_q);
        count_d = count_q;
        tick_d  = 1'b0;
        case (mode_s)
            MODE_RUN: begin
                count_d = acc_sum[ACC_W-1:0];
                tick_d  = acc_sum[ACC_W];
            end
            MODE_SINGLE: tick_d = req_edge;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q  <= STEP_INIT_V;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            step_q  <= step_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

`ifdef EVOLVE_GEN_COUNTER_EN
    logic [GEN_W-1:0] gen_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            gen_q <= '0;
        end else if (tick_q) begin
            gen_q <= gen_q + GEN_W'(1);
        end
    end

    assign gen = gen_q;
`else
    assign gen = '0;
`endif

    assign envolve_v = tick_q;
    assign step      = step_q;
    assign count     = count_q;
    assign at_min    = (step_q == STEP_MIN_V);
    assign at_max    = (step_q == STEP_MAX_V);

endmodule
